// File: rtl/seg7_number_display.sv
// seg7_number_display
// Drives DIGITS active-low seven-segment digits from a WIDTH-bit unsigned
// value, in hexadecimal or decimal (sequential double-dabble conversion).
// Supports leading-zero blanking and decimal overflow indication (all
// dashes). A load/busy/done handshake frames each conversion.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   value     number to display, sampled on an accepted load
//   load      start a conversion (ignored while busy)
//   dec_mode  1 = decimal, 0 = hexadecimal (sampled with load)
//   blank_lz  1 = blank leading zero digits (sampled with load)
//   busy      high while state != IDLE
//   done      one-cycle pulse when hex has just been written
//   hex       digit i in hex[8i+7:8i], active-low {dp,g,f,e,d,c,b,a}
//
// state   | meaning
// IDLE    | waiting for load
// CONVERT | WIDTH double-dabble shift cycles
// UPDATE  | write hex, pulse done
module seg7_number_display #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      value,
  input  logic                  load,
  input  logic                  dec_mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*8-1:0]   hex
);

  localparam int BW   = 4 * DIGITS;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int EXTW = (WIDTH > BW) ? WIDTH : BW;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  localparam longint unsigned LIMIT = pow10(DIGITS);

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;
      4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;
      4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                dec_q, dec_d;
  logic                blz_q, blz_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DIGITS*8-1:0] hex_q, hex_d;

  logic [BW-1:0]       bcd_adj;
  logic [EXTW-1:0]     ext;
  logic [BW-1:0]       digit_vals;
  logic [DIGITS*8-1:0] glyphs;
  logic                seen_nz;

  // Add-3 correction applied before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Glyph selection; digits are scanned from the top so a digit is blanked
  // only if it and everything above it are zero. Digit 0 is never blanked.
  always_comb begin
    ext        = EXTW'(bin_q);
    digit_vals = dec_q ? bcd_q : ext[BW-1:0];
    glyphs     = '1;
    seen_nz    = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (digit_vals[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      if (ovf_q)
        glyphs[8*i +: 8] = 8'hBF;
      else if (blz_q && !seen_nz && i != 0)
        glyphs[8*i +: 8] = 8'hFF;
      else
        glyphs[8*i +: 8] = glyph(digit_vals[4*i +: 4]);
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    blz_d   = blz_q;
    ovf_d   = ovf_q;
    hex_d   = hex_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d   = value;
          dec_d   = dec_mode;
          blz_d   = blank_lz;
          ovf_d   = dec_mode && (64'(value) >= LIMIT);
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = dec_mode ? CONVERT : UPDATE;
        end
      end
      CONVERT: begin
        bcd_d = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
        bin_d = bin_q << 1;
        if (cnt_q == '0) state_d = UPDATE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      UPDATE: begin
        hex_d   = glyphs;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      blz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hex_q   <= '1;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      blz_q   <= blz_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hex_q   <= hex_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hex  = hex_q;

endmodule

// File: doc/seg7_number_display.md
# seg7_number_display

Parametrised seven-segment number display driver for the DE10-Lite style board: it takes a WIDTH-bit unsigned value and drives DIGITS active-low seven-segment digits. Each digit is 8 bits with the decimal point in bit 7. It supersedes the fixed 0–7 single-digit decoder by adding:
- the full hex glyph set;
- a sequential binary-to-BCD (double-dabble) decimal mode;
- leading-zero blanking and overflow indication;
- a load/busy/done handshake.

It sits between the switch or datapath value and the HEXn outputs of the top level.

## Interface
- DIGITS, 4, number of seven-segment digits driven (1–6)
- WIDTH, 10, width of the input value (1–20)
- clk  in  1  single system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- value  in  WIDTH  unsigned number to display; sampled only on an accepted load
- load  in  1  request to convert and display `value`
- dec_mode  in  1  1 = decimal, 0 = hexadecimal; sampled with `load`
- blank_lz  in  1  1 = blank leading zero digits; sampled with `load`
- busy  out  1  high while a conversion is in progress (state ≠ IDLE)
- done  out  1  one-cycle pulse when `hex` has just been updated
- hex  out  DIGITS*8  digit i in hex[8i+7:8i], digit 0 least significant; active-low {dp,g,f,e,d,c,b,a}

## Operation

**Glyphs** (dp always off, bit 7 = 1):
- 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
- 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- blank=FF, dash=BF

**State machine:** IDLE, CONVERT, UPDATE.
- **IDLE:** `load`=1 captures `value`, `dec_mode` and `blank_lz`.
  - In decimal mode the block clears the BCD register, loads the shift register and goes to CONVERT.
  - In hex mode it goes to UPDATE.
  - `load`=0 keeps the block in IDLE.
- **CONVERT:**
  - Exactly WIDTH cycles.
  - Each cycle adds 3 to every BCD nibble ≥5, then shifts the {BCD, binary} register left by one.
  - After the WIDTH-th shift the block goes to UPDATE.
- **UPDATE:**
  - On the next edge the block writes `hex`, asserts `done` for one cycle and returns to IDLE.

**Digit values:**
- Hex mode: digit i = value[4i+3:4i], with bits above WIDTH read as zero.
- Decimal mode: digit i = BCD nibble i.

**Overflow:**
- In decimal mode, if the captured value ≥ 10^DIGITS (compared against a constant at load), every digit shows dash.
- In hex mode, if WIDTH > 4*DIGITS, the upper bits are silently truncated.

**Leading-zero blanking:**
- With `blank_lz`=1, zero digits above the most significant nonzero digit show blank.
- Digit 0 is never blanked, so a value of 0 shows a single "0".
- Blanking applies in both modes and is suppressed on overflow.

**Handshake and holding:**
- `load` while `busy`=1 is ignored; it is neither queued nor does it corrupt the conversion.
- `hex` holds its last written value until the next UPDATE.
- `value` may change freely after the load edge.

## Timing
- **Reset values:** `hex` = all FF (all digits blank), `busy`=0, `done`=0, state IDLE, internal registers 0.
- **Reset mid-operation:** reset during CONVERT or UPDATE aborts; `hex` goes to all blank and `done` is not pulsed.
- **Load edge:** the load edge E0 sets `busy`=1 in the following cycle.
- **Hex mode latency:** `hex` is updated and `done`=1 after E0+1, and `busy`=0 in that same cycle.
- **Decimal mode latency:** `hex` is updated and `done`=1 after E0+WIDTH+1. With WIDTH=10 that is 11 edges, and `busy` is high for 11 cycles.
- **Back-to-back loads:** `load`=1 in the cycle where `done`=1 is accepted, because the block is in IDLE.
- **Simultaneous reset and load:** reset wins.
- **Outputs:** all outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- **Reset:** assert reset 2 cycles → `hex`=FFFFFFFF, `busy`=0, `done`=0. Then apply `load` with reset high → no conversion starts.
- **Hex mode:** DIGITS=4, WIDTH=10, value=0x2A3, `dec_mode`=0, `blank_lz`=0 → after 2 edges, `hex`={C0,A4,88,B0} (digit3..0), `done` pulses once.
- **Decimal mode:** value=1023, `dec_mode`=1 → `busy` high 11 cycles, then `hex`={F9,C0,A4,B0}. Then value=7 with `blank_lz`=1 → `hex`={FF,FF,FF,F8}. Then value=0 → `hex`={FF,FF,FF,C0}.
- **Overflow:** DIGITS=2, WIDTH=10, value=100, decimal → `hex`={BF,BF}. Then value=99 → `hex`={90,90}.
- **Handshake:** `load` with value=5 in decimal mode, then `load` with value=9 three cycles later → only one `done`, `hex` digit0=92. A new `load` in the `done` cycle is accepted.
- **Reset mid-conversion:** reset after 4 CONVERT cycles → `hex` all FF, no `done`. A subsequent load of 42 → {…,99,A4} after 11 edges.
